// File: rtl/delay_ctrl.sv
// Sequencer for the mic delay line: turns per-sample ticks into RAM write/read enables,
// applies delay offset changes by re-priming the buffer, and flags busy while priming.
module delay_ctrl #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sample_tick,
    input  logic [A_WIDTH-1:0] offset_in,
    output logic               wr,
    output logic               rd,
    output logic [A_WIDTH-1:0] offset,
    output logic               ptr_clr,
    output logic               delayed_valid,
    output logic               busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // A zero-width sample bus would make the delay line meaningless.
    if (D_WIDTH < 1) begin : g_badDataWidth
    end

    logic [1:0]         r_state;
    logic               r_wr;
    logic               r_rd;
    logic               r_ptrClr;
    logic               r_delayedValid;
    logic               r_busy;
    logic [A_WIDTH-1:0] r_offset;
    logic [A_WIDTH-1:0] r_fillCnt;

    logic [A_WIDTH-1:0] w_offsetEff;
    logic [A_WIDTH-1:0] w_fillNext;

    // A zero delay is not representable by the RAM, so it is treated as one sample.
    assign w_offsetEff = (offset_in == '0) ? A_WIDTH'(1) : offset_in;
    assign w_fillNext  = r_fillCnt + A_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_wr           <= 1'b0;
            r_rd           <= 1'b0;
            r_ptrClr       <= 1'b0;
            r_delayedValid <= 1'b0;
            r_busy         <= 1'b0;
            r_offset       <= A_WIDTH'(1);
            r_fillCnt      <= '0;
        end else if (!en) begin
            r_state        <= ST_IDLE;
            r_wr           <= 1'b0;
            r_rd           <= 1'b0;
            r_ptrClr       <= 1'b0;
            r_delayedValid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_wr           <= 1'b0;
            r_rd           <= 1'b0;
            r_ptrClr       <= 1'b0;
            r_delayedValid <= r_rd;
            case (r_state)
                ST_IDLE: begin
                    r_state   <= ST_PRIME;
                    r_offset  <= w_offsetEff;
                    r_ptrClr  <= 1'b1;
                    r_fillCnt <= '0;
                    r_busy    <= 1'b1;
                end
                ST_PRIME: begin
                    r_busy <= 1'b1;
                    // The datapath counter is being cleared while ptr_clr is high.
                    if (sample_tick && !r_ptrClr) begin
                        r_wr      <= 1'b1;
                        r_fillCnt <= w_fillNext;
                        if (w_fillNext == r_offset) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    r_busy <= 1'b0;
                    if (sample_tick) begin
                        if (w_offsetEff != r_offset) begin
                            r_state   <= ST_PRIME;
                            r_offset  <= w_offsetEff;
                            r_ptrClr  <= 1'b1;
                            r_fillCnt <= '0;
                            r_busy    <= 1'b1;
                        end else begin
                            r_wr <= 1'b1;
                            r_rd <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr            = r_wr;
    assign rd            = r_rd;
    assign offset        = r_offset;
    assign ptr_clr       = r_ptrClr;
    assign delayed_valid = r_delayedValid;
    assign busy          = r_busy;

endmodule

// File: tb/tb_delay_ctrl.sv
// Testbench for delay_ctrl: directed scenarios plus random traffic, every cycle compared
// against a behavioural model that tracks mode, applied delay and writes still to prime.
module tb_delay_ctrl;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          sample_tick = 1'b0;
    logic [AW-1:0] offset_in = '0;
    logic          wr;
    logic          rd;
    logic [AW-1:0] offset;
    logic          ptr_clr;
    logic          delayed_valid;
    logic          busy;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: mode 0 = idle, 1 = priming, 2 = running.
    int mMode      = 0;
    int mOffset    = 1;
    int mWritesDue = 0;
    int eOff       = 1;
    bit eWr, eRd, eDv, eClr, eBusy;

    int primeWrites;
    int curOff;

    always #5 clk = ~clk;

    delay_ctrl #(.A_WIDTH(AW), .D_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .sample_tick   (sample_tick),
        .offset_in     (offset_in),
        .wr            (wr),
        .rd            (rd),
        .offset        (offset),
        .ptr_clr       (ptr_clr),
        .delayed_valid (delayed_valid),
        .busy          (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input bit r, input bit e, input bit t, input int off);
        int eff;
        bit prevRd;
        bit prevClr;
        eff     = (off == 0) ? 1 : off;
        prevRd  = eRd;
        prevClr = eClr;
        if (r) begin
            mMode = 0; mOffset = 1; mWritesDue = 0;
            {eWr, eRd, eDv, eClr, eBusy} = '0;
        end else if (!e) begin
            mMode = 0;
            {eWr, eRd, eDv, eClr, eBusy} = '0;
        end else begin
            eWr = 0; eRd = 0; eClr = 0;
            eDv = prevRd;
            if (mMode == 0) begin
                mMode = 1; mOffset = eff; mWritesDue = eff;
                eClr = 1; eBusy = 1;
            end else if (mMode == 1) begin
                eBusy = 1;
                if (t && !prevClr) begin
                    eWr = 1;
                    mWritesDue--;
                    if (mWritesDue == 0) begin
                        mMode = 2; eBusy = 0;
                    end
                end
            end else begin
                eBusy = 0;
                if (t) begin
                    if (eff != mOffset) begin
                        mMode = 1; mOffset = eff; mWritesDue = eff;
                        eClr = 1; eBusy = 1;
                    end else begin
                        eWr = 1; eRd = 1;
                    end
                end
            end
        end
        eOff = mOffset;
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit t, input int off);
        @(negedge clk);
        rst         = r;
        en          = e;
        sample_tick = t;
        offset_in   = AW'(off);
        @(posedge clk);
        modelStep(r, e, t, off);
        #1;
        checkOutput("wr", 32'(wr), 32'(eWr));
        checkOutput("rd", 32'(rd), 32'(eRd));
        checkOutput("delayed_valid", 32'(delayed_valid), 32'(eDv));
        checkOutput("ptr_clr", 32'(ptr_clr), 32'(eClr));
        checkOutput("busy", 32'(busy), 32'(eBusy));
        checkOutput("offset", 32'(offset), 32'(eOff));
    endtask

    task automatic tickEvery(input int gap, input int count, input int off);
        for (int i = 0; i < count; i++) begin
            applyStimulus(0, 1, 1, off);
            for (int j = 1; j < gap; j++) applyStimulus(0, 1, 0, off);
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(1, 0, 0, 4);
        applyStimulus(1, 0, 0, 4);
        checkOutput("reset_offset", 32'(offset), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);

        // Basic prime and run with offset 4, ticks every 3 cycles
        tickEvery(3, 9, 4);
        checkOutput("run_busy_low", 32'(busy), 32'd0);

        // Delay change 4 -> 7 while running, including a change between ticks
        applyStimulus(0, 1, 0, 7);
        tickEvery(3, 10, 7);
        checkOutput("offset_now_7", 32'(offset), 32'd7);

        // Zero request clamps to one sample
        applyStimulus(1, 0, 0, 0);
        tickEvery(2, 5, 0);
        checkOutput("clamp_offset_1", 32'(offset), 32'd1);

        // en dropped in the cycle after a running tick, then full re-prime
        applyStimulus(1, 0, 0, 4);
        tickEvery(3, 7, 4);
        applyStimulus(0, 1, 1, 4);
        applyStimulus(0, 0, 0, 4);
        checkOutput("en_drop_dv", 32'(delayed_valid), 32'd0);
        applyStimulus(0, 0, 1, 4);
        tickEvery(3, 8, 4);

        // Maximum delay with back-to-back ticks
        applyStimulus(1, 0, 0, 511);
        primeWrites = 0;
        for (int i = 0; i < 530; i++) begin
            applyStimulus(0, 1, 1, 511);
            if (wr === 1'b1 && rd === 1'b0) primeWrites++;
        end
        checkOutput("prime_writes_511", 32'(primeWrites), 32'd511);
        checkOutput("b2b_wr", 32'(wr), 32'd1);
        checkOutput("b2b_rd", 32'(rd), 32'd1);

        // Reset mid-prime
        applyStimulus(1, 0, 0, 6);
        tickEvery(1, 4, 6);
        applyStimulus(1, 1, 1, 6);
        checkOutput("mid_rst_offset", 32'(offset), 32'd1);
        checkOutput("mid_rst_wr", 32'(wr), 32'd0);

        // Random traffic
        curOff = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) curOff = $urandom_range(0, 12);
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 49) != 0,
                          $urandom_range(0, 2) == 0, curOff);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
